// File: rtl/eda_regional_extrema.sv
// Self-sequencing regional-maximum/minimum engine.
// Holds an M x N image. On start it flood-fills each equal-valued plateau through
// an internal queue and marks the plateau if no in-bounds neighbour beats it.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   write_en/wr_addr/pixel_in  pixel load port, ignored while busy
//   start                  single-cycle run request, ignored while busy
//   busy, done             run in progress, one-cycle completion pulse
//   rd_addr, mask_out      registered mask read, forced 0 while busy
//   region_count           number of extremal plateaus from the last run
module eda_regional_extrema #(
  parameter int unsigned M           = 6,
  parameter int unsigned N           = 6,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CONN        = 8,
  parameter int unsigned MODE_MIN    = 0,
  parameter int unsigned ADDR_WIDTH  = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [PIXEL_WIDTH-1:0]  pixel_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    mask_out,
  output logic [ADDR_WIDTH:0]     region_count
);

  localparam int unsigned NPIX = M * N;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(NPIX - 1);
  localparam logic [2:0]            K_LAST = 3'(CONN - 1);
  localparam logic [ADDR_WIDTH:0]   ONE    = (ADDR_WIDTH + 1)'(1);

  generate
    if (CONN != 4 && CONN != 8) begin : g_bad_conn
      $error("eda_regional_extrema: CONN must be 4 or 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SCAN, S_SEED, S_POP, S_NEIGH, S_MARK, S_FIN
  } state_t;

  state_t                  state;
  logic [PIXEL_WIDTH-1:0]  pix   [NPIX];
  logic [ADDR_WIDTH-1:0]   queue [NPIX];
  logic [NPIX-1:0]         visited;
  logic [NPIX-1:0]         mask;
  logic [ADDR_WIDTH-1:0]   scan_addr;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [ADDR_WIDTH:0]     head;
  logic [ADDR_WIDTH:0]     tail;
  logic [ADDR_WIDTH:0]     idx;
  logic [2:0]              k;
  logic                    is_ext;

  int                      dr, dc, c_row, c_col, nb_row, nb_col;
  logic                    in_b, beats, enq, show_mask, rd_bit;
  logic [ADDR_WIDTH-1:0]   nb_addr;
  logic [PIXEL_WIDTH-1:0]  c_val, nb_val;
  logic [ADDR_WIDTH:0]     tail_next;

  // Neighbour offset for step k, bounds check and beat/equal classification.
  always_comb begin
    dr = 0;
    dc = 0;
    if (CONN == 8) begin
      case (k)
        3'd0:    begin dr = -1; dc = -1; end
        3'd1:    begin dr = -1; dc =  0; end
        3'd2:    begin dr = -1; dc =  1; end
        3'd3:    begin dr =  0; dc = -1; end
        3'd4:    begin dr =  0; dc =  1; end
        3'd5:    begin dr =  1; dc = -1; end
        3'd6:    begin dr =  1; dc =  0; end
        default: begin dr =  1; dc =  1; end
      endcase
    end else begin
      case (k)
        3'd0:    begin dr = -1; dc =  0; end
        3'd1:    begin dr =  0; dc = -1; end
        3'd2:    begin dr =  0; dc =  1; end
        default: begin dr =  1; dc =  0; end
      endcase
    end
    c_row   = int'(c_addr) / int'(N);
    c_col   = int'(c_addr) % int'(N);
    nb_row  = c_row + dr;
    nb_col  = c_col + dc;
    in_b    = (nb_row >= 0) && (nb_row < int'(M)) && (nb_col >= 0) && (nb_col < int'(N));
    nb_addr = ADDR_WIDTH'(nb_row * int'(N) + nb_col);
    c_val   = pix[c_addr];
    nb_val  = pix[nb_addr];
    beats   = (MODE_MIN != 0) ? (nb_val < c_val) : (nb_val > c_val);
    enq     = (state == S_NEIGH) && in_b && !beats && (nb_val == c_val) && !visited[nb_addr];
    tail_next = tail + (ADDR_WIDTH + 1)'(enq);
    show_mask = ((state == S_IDLE) && !start) || (state == S_FIN);
    rd_bit    = (32'(rd_addr) < NPIX) ? mask[rd_addr] : 1'b0;
  end

  // Pixel RAM: loads only while idle.
  always_ff @(posedge clk) begin
    if (write_en && !busy && (32'(wr_addr) < NPIX)) pix[wr_addr] <= pixel_in;
  end

  // Plateau queue RAM: seed entry, then neighbours as they are discovered.
  always_ff @(posedge clk) begin
    if (state == S_SEED)  queue[0] <= scan_addr;
    else if (enq)         queue[tail[ADDR_WIDTH-1:0]] <= nb_addr;
  end

  // Sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mask_out     <= 1'b0;
      region_count <= '0;
      visited      <= '0;
      mask         <= '0;
      scan_addr    <= '0;
      c_addr       <= '0;
      head         <= '0;
      tail         <= '0;
      idx          <= '0;
      k            <= '0;
      is_ext       <= 1'b0;
    end else begin
      done     <= 1'b0;
      mask_out <= show_mask ? rd_bit : 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_CLR;
            busy         <= 1'b1;
            region_count <= '0;
            scan_addr    <= '0;
          end
        end
        S_CLR: begin
          visited[scan_addr] <= 1'b0;
          mask[scan_addr]    <= 1'b0;
          if (scan_addr == LAST) begin
            scan_addr <= '0;
            state     <= S_SCAN;
          end else begin
            scan_addr <= scan_addr + 1'b1;
          end
        end
        S_SCAN: begin
          if (!visited[scan_addr])    state <= S_SEED;
          else if (scan_addr == LAST) state <= S_FIN;
          else                        scan_addr <= scan_addr + 1'b1;
        end
        S_SEED: begin
          visited[scan_addr] <= 1'b1;
          head   <= '0;
          tail   <= ONE;
          is_ext <= 1'b1;
          state  <= S_POP;
        end
        S_POP: begin
          c_addr <= queue[head[ADDR_WIDTH-1:0]];
          head   <= head + ONE;
          k      <= '0;
          state  <= S_NEIGH;
        end
        S_NEIGH: begin
          if (in_b && beats) is_ext <= 1'b0;
          if (enq) visited[nb_addr] <= 1'b1;
          tail <= tail_next;
          if (k == K_LAST) begin
            if (head != tail_next) state <= S_POP;
            else begin
              idx   <= '0;
              state <= S_MARK;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        S_MARK: begin
          mask[queue[idx[ADDR_WIDTH-1:0]]] <= is_ext;
          if (idx == tail - ONE) begin
            region_count <= region_count + (ADDR_WIDTH + 1)'(is_ext);
            if (scan_addr == LAST) state <= S_FIN;
            else begin
              scan_addr <= scan_addr + 1'b1;
              state     <= S_SCAN;
            end
          end else begin
            idx <= idx + ONE;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eda_regional_extrema.sv
// Self-checking bench for eda_regional_extrema: four instances cover CONN=8,
// CONN=4, MODE_MIN=1 and a 3x5 image. Expected results go into a scoreboard
// queue when a run is started and are popped when that run's done pulse is seen.
module tb_eda_regional_extrema;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    we, st;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    pixel_in;
  logic [3:0]    busy_v, done_v, mask_v;
  logic [AW:0]   rc [4];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] mask;
    logic [4:0]  count;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  eda_regional_extrema #(.M(4), .N(4), .PIXEL_WIDTH(8), .CONN(8), .MODE_MIN(0)) u_c8 (
    .clk(clk), .reset_n(reset_n), .write_en(we[0]), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .start(st[0]), .busy(busy_v[0]), .done(done_v[0]), .rd_addr(rd_addr),
    .mask_out(mask_v[0]), .region_count(rc[0]));
  eda_regional_extrema #(.M(4), .N(4), .PIXEL_WIDTH(8), .CONN(4), .MODE_MIN(0)) u_c4 (
    .clk(clk), .reset_n(reset_n), .write_en(we[1]), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .start(st[1]), .busy(busy_v[1]), .done(done_v[1]), .rd_addr(rd_addr),
    .mask_out(mask_v[1]), .region_count(rc[1]));
  eda_regional_extrema #(.M(4), .N(4), .PIXEL_WIDTH(8), .CONN(8), .MODE_MIN(1)) u_min (
    .clk(clk), .reset_n(reset_n), .write_en(we[2]), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .start(st[2]), .busy(busy_v[2]), .done(done_v[2]), .rd_addr(rd_addr),
    .mask_out(mask_v[2]), .region_count(rc[2]));
  eda_regional_extrema #(.M(3), .N(5), .PIXEL_WIDTH(8), .CONN(8), .MODE_MIN(0)) u_35 (
    .clk(clk), .reset_n(reset_n), .write_en(we[3]), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .start(st[3]), .busy(busy_v[3]), .done(done_v[3]), .rd_addr(rd_addr),
    .mask_out(mask_v[3]), .region_count(rc[3]));

  task automatic load(input int d, input int a, input int v);
    we[d] = 1'b1; wr_addr = AW'(a); pixel_in = 8'(v);
    @(posedge clk); #1;
    we[d] = 1'b0;
  endtask

  task automatic fill(input int d, input int n, input int v);
    for (int a = 0; a < n; a++) load(d, a, v);
  endtask

  // Starts instance d and waits (bounded) for done. Optionally writes a pixel in
  // the start cycle, and injects a start+write pair at cycle inj.
  task automatic run_dut(input int d, input int inj, input bit pre_we, input int pre_a,
                         input int pre_v, output int cycles, output int pulses,
                         output bit timeout, output bit leak, output bit busy_at_done);
    cycles = 0; pulses = 0; leak = 1'b0; busy_at_done = 1'b1;
    st[d] = 1'b1;
    if (pre_we) begin we[d] = 1'b1; wr_addr = AW'(pre_a); pixel_in = 8'(pre_v); end
    do begin
      @(posedge clk); cycles++; #1;
      st[d] = 1'b0; we[d] = 1'b0;
      if (cycles == inj) begin st[d] = 1'b1; we[d] = 1'b1; wr_addr = '0; pixel_in = 8'd99; end
      if (busy_v[d] && mask_v[d]) leak = 1'b1;
    end while (!done_v[d] && cycles < 1000);
    timeout = !done_v[d];
    if (!timeout) begin pulses = 1; busy_at_done = busy_v[d]; end
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (done_v[d]) pulses++; end
  endtask

  task automatic read_mask(input int d, input int n, output logic [15:0] got);
    got = '0;
    for (int a = 0; a < n; a++) begin
      rd_addr = AW'(a);
      @(posedge clk); #1;
      got[a] = mask_v[d];
    end
  endtask

  task automatic test_reset;
    logic [15:0] got;
    for (int d = 0; d < 4; d++) begin
      checks++; if (busy_v[d] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, busy_v[d]); end
      checks++; if (done_v[d] !== 1'b0) begin failures++; $display("FAIL reset_done dut%0d got=%b exp=0", d, done_v[d]); end
      checks++; if (rc[d] !== 5'd0) begin failures++; $display("FAIL reset_count dut%0d got=%0d exp=0", d, rc[d]); end
    end
    read_mask(0, 16, got);
    checks++; if (got !== 16'h0000) begin failures++; $display("FAIL reset_mask got=%h exp=0000", got); end
  endtask

  task automatic test_all_equal;
    int cyc, pul; bit to, lk, bd; logic [15:0] got; exp_t e;
    fill(0, 16, 7);
    rd_addr = '0;
    sb.push_back('{16'hFFFF, 5'd1, 195});
    run_dut(0, 0, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL s1_timeout got=%b exp=0", to); end
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s1_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (pul !== 1) begin failures++; $display("FAIL s1_done_pulses got=%0d exp=1", pul); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL s1_busy_at_done got=%b exp=0", bd); end
    checks++; if (lk !== 1'b0) begin failures++; $display("FAIL s1_mask_while_busy got=%b exp=0", lk); end
    checks++; if (rc[0] !== e.count) begin failures++; $display("FAIL s1_count got=%0d exp=%0d", rc[0], e.count); end
    read_mask(0, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s1_mask got=%h exp=%h", got, e.mask); end
  endtask

  // Single peak, checked as a maximum (CONN=8) and as a minimum image.
  task automatic test_single_peak;
    int cyc, pul; bit to, lk, bd; logic [15:0] got; exp_t e;
    fill(0, 16, 0); load(0, 6, 9);
    fill(2, 16, 0); load(2, 6, 9);
    rd_addr = AW'(0);
    sb.push_back('{16'h0040, 5'd1, 196});
    run_dut(0, 0, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s2_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (rc[0] !== e.count) begin failures++; $display("FAIL s2_count got=%0d exp=%0d", rc[0], e.count); end
    read_mask(0, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s2_mask got=%h exp=%h", got, e.mask); end
    sb.push_back('{16'hFFBF, 5'd1, 196});
    run_dut(2, 0, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s4_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (pul !== 1) begin failures++; $display("FAIL s4_done_pulses got=%0d exp=1", pul); end
    checks++; if (rc[2] !== e.count) begin failures++; $display("FAIL s4_count got=%0d exp=%0d", rc[2], e.count); end
    read_mask(2, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s4_mask got=%h exp=%h", got, e.mask); end
  endtask

  task automatic test_diagonal;
    int cyc, pul; bit to, lk, bd; logic [15:0] got; exp_t e;
    fill(0, 16, 0); load(0, 0, 5); load(0, 5, 5);
    fill(1, 16, 0); load(1, 0, 5); load(1, 5, 5);
    sb.push_back('{16'h0021, 5'd2, 133});
    run_dut(1, 0, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s3c4_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (rc[1] !== e.count) begin failures++; $display("FAIL s3c4_count got=%0d exp=%0d", rc[1], e.count); end
    read_mask(1, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s3c4_mask got=%h exp=%h", got, e.mask); end
    sb.push_back('{16'h0021, 5'd1, 196});
    run_dut(0, 0, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s3c8_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (rc[0] !== e.count) begin failures++; $display("FAIL s3c8_count got=%0d exp=%0d", rc[0], e.count); end
    read_mask(0, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s3c8_mask got=%h exp=%h", got, e.mask); end
  endtask

  // 3x5 row-wrap image; pixel 5 is written in the same cycle as start.
  task automatic test_row_wrap;
    int cyc, pul; bit to, lk, bd; logic [15:0] got; exp_t e;
    fill(3, 15, 1); load(3, 4, 100);
    sb.push_back('{16'h0030, 5'd2, 185});
    run_dut(3, 0, 1'b1, 5, 150, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s5_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (rc[3] !== e.count) begin failures++; $display("FAIL s5_count got=%0d exp=%0d", rc[3], e.count); end
    read_mask(3, 15, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s5_mask got=%h exp=%h", got, e.mask); end
  endtask

  task automatic test_reset_mid_run;
    int cyc, pul; bit to, lk, bd; logic [15:0] got; exp_t e;
    fill(0, 16, 7);
    rd_addr = '0;
    st[0] = 1'b1; @(posedge clk); #1; st[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1; reset_n = 1'b0; #2;
    checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL s6_abort_busy got=%b exp=0", busy_v[0]); end
    checks++; if (mask_v[0] !== 1'b0) begin failures++; $display("FAIL s6_abort_mask got=%b exp=0", mask_v[0]); end
    checks++; if (rc[0] !== 5'd0) begin failures++; $display("FAIL s6_abort_count got=%0d exp=0", rc[0]); end
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{16'hFFFF, 5'd1, 195});
    run_dut(0, 5, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL s6_cycles got=%0d exp=%0d", cyc, e.cycles); end
    checks++; if (pul !== 1) begin failures++; $display("FAIL s6_done_pulses got=%0d exp=1", pul); end
    checks++; if (rc[0] !== e.count) begin failures++; $display("FAIL s6_count got=%0d exp=%0d", rc[0], e.count); end
    read_mask(0, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s6_mask got=%h exp=%h", got, e.mask); end
    // A rerun exposes a mid-run write that should have been dropped.
    sb.push_back('{16'hFFFF, 5'd1, 195});
    run_dut(0, 0, 1'b0, 0, 0, cyc, pul, to, lk, bd);
    e = sb.pop_front();
    checks++; if (rc[0] !== e.count) begin failures++; $display("FAIL s6_rerun_count got=%0d exp=%0d", rc[0], e.count); end
    read_mask(0, 16, got);
    checks++; if (got !== e.mask) begin failures++; $display("FAIL s6_rerun_mask got=%h exp=%h", got, e.mask); end
  endtask

  initial begin
    we = '0; st = '0; wr_addr = '0; rd_addr = '0; pixel_in = '0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    test_reset;
    test_all_equal;
    test_single_peak;
    test_diagonal;
    test_row_wrap;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eda_regional_extrema.md
Name: eda_regional_extrema

Overview:
- Self-sequencing regional-maximum/minimum engine. It is the next generation of the externally-stepped regional-max datapath (image RAM, compare, iterated RAM).
- Holds an M x N image and, on `start`, walks every pixel on its own. It flood-fills each equal-valued plateau through an internal queue and decides whether the whole plateau is a regional extremum.
- Writes a per-pixel result mask and a plateau count, both readable once the run completes.
- Generalised over image size, pixel width, connectivity (4/8) and polarity (max/min).

Parameters:
- `M`, 6, image rows.
- `N`, 6, image columns.
- `PIXEL_WIDTH`, 8, bits per pixel (unsigned).
- `CONN`, 8, connectivity; legal values 4 or 8, anything else is an elaboration error.
- `MODE_MIN`, 0, 0 = regional maxima, 1 = regional minima.
- `ADDR_WIDTH`, `$clog2(M*N)`, pixel address width. Address = `row*N + col`, row-major.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `write_en`  in  1  pixel load strobe; ignored while `busy`.
- `wr_addr`  in  `ADDR_WIDTH`  load address.
- `pixel_in`  in  `PIXEL_WIDTH`  load data.
- `start`  in  1  single-cycle run request; ignored while `busy`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `rd_addr`  in  `ADDR_WIDTH`  mask read address.
- `mask_out`  out  1  mask bit at `rd_addr`, registered, 1-cycle latency; forced 0 while `busy`.
- `region_count`  out  `ADDR_WIDTH+1`  number of extremal plateaus found by the last run.

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE.
  - `busy`=0, `done`=0, `mask_out`=0, `region_count`=0.
  - Mask bits and visited bits cleared.
  - Pixel RAM is not reset.
- Storage:
  - Pixel RAM `M*N x PIXEL_WIDTH`, synchronous write, combinational read.
  - Visited and mask arrays: `M*N` bits each, flops.
  - Queue RAM: `M*N x ADDR_WIDTH`, with `head`/`tail` pointers. It never overflows, because each pixel is enqueued at most once per run.
- "Beats" is the extremal comparison:
  - `MODE_MIN`=0: neighbour > centre.
  - `MODE_MIN`=1: neighbour < centre.
  - Unsigned compare.
- Neighbour order:
  - CONN=8: UL, U, UR, L, R, DL, D, DR.
  - CONN=4: U, L, R, D.
  - Out-of-bounds neighbours (row < 0, row >= M, col < 0, col >= N) are skipped but still cost their cycle.
  - No wrap between rows: (r, N-1) is not adjacent to (r+1, 0).
- FSM, one transition per clock:
  - IDLE: on `start`, go to CLR; `busy`=1; `region_count`=0.
  - CLR: clear visited[a] and mask[a], one address per cycle for a = 0..M*N-1; then go to SCAN with scan_addr=0.
  - SCAN: 1 cycle per address.
    - If visited[scan_addr], increment scan_addr.
    - Otherwise go to SEED.
    - After address M*N-1, go to FIN.
  - SEED: visited[scan]=1, queue[0]=scan, head=0, tail=1, is_ext=1. Go to POP.
  - POP: centre=queue[head], head++, k=0. Go to NEIGH.
  - NEIGH: 1 cycle per k = 0..CONN-1.
    - If neighbour in bounds and "beats" centre: is_ext=0.
    - Else if in bounds, equal to centre and not visited: set visited, queue[tail]=nb, tail++.
    - Same-cycle visited set and enqueue are consistent for subsequent k.
    - After the last k: go to POP if head != tail, else go to MARK with idx=0.
  - MARK: mask[queue[idx]] = is_ext, one per cycle for idx = 0..tail-1. Then `region_count` += is_ext, scan_addr++, and go to SCAN (or FIN if scan_addr was M*N-1).
  - FIN: 1 cycle, `busy`=0, `done`=1. Go to IDLE.
- Cycle cost:
  - M*N (CLR) + M*N (SCAN) + 2 (FIN path)
  - plus, per plateau P: 1 + |P|*(1+CONN) + |P|.
- `done` is exactly one cycle wide and coincides with `busy` falling.
- Mask and `region_count` hold their values until the next `start` or reset.
- Simultaneous `start` and `write_en` in IDLE: the write is performed and the run starts the next cycle. The write lands before CLR reads any pixel.
- `start` while `busy`: ignored, no restart.
- Reset mid-run: immediate abort; outputs per the reset state; a fresh `start` gives a correct result.
- M*N=1: the single pixel is an extremum; mask[0]=1, count=1.

Test Plan:
1. 4x4 image, all pixels = 7, CONN=8, MODE_MIN=0 → all 16 mask bits 1; `region_count`=1; `done` pulses once.
2. 4x4 image of zeros with pixel 9 at addr 6 → mask 1 only at addr 6; `region_count`=1.
3. 4x4 zeros with 5 at addr 0 and addr 5 (diagonal):
   - CONN=4 → `region_count`=2.
   - CONN=8 → `region_count`=1.
   - In both cases mask=1 at addr 0 and 5 only.
4. MODE_MIN=1 on the scenario 2 image → mask 1 at all addresses except 6; `region_count`=1.
5. M=3, N=5, pixels all 1, addr 4=100, addr 5=150 (row-wrap check) → mask 1 at addr 4 and 5 only; `region_count`=2.
6. Reset, `start` and write interaction:
   - Pulse `reset_n` low during NEIGH of scenario 1 → `busy`=0, `mask_out`=0, `region_count`=0.
   - Then `start` → scenario 1 result is reproduced.
   - A second `start` and a `write_en` issued mid-run have no effect.
